// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX observation inputs, pipeline-register
// write/flush controls, and performance-debug status.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_jump;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_multicycle;
  logic        ex_branch_taken;
  logic        perf_clear;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt,
           ex_multicycle, ex_branch_taken, perf_clear,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_flush, state, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt,
           ex_multicycle, ex_branch_taken, perf_clear,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_flush, state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch/jump
// squashes, multi-cycle EX freeze, and saturating stall/flush counters.
//
// state   | meaning
// RUN     | normal issue; all hazard rules evaluated
// MULTI   | multi-cycle EX op in flight; pipeline frozen, inputs ignored
// RELEASE | op leaves EX this cycle; ex_multicycle ignored, other rules apply
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULTI   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] REM_LOAD = 8'(MULDIV_CYCLES - 2);

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] stall_q, flush_q;
  logic        load_use;
  logic        pc_write, if_id_write, if_id_flush;
  logic        id_ex_write, id_ex_flush, ex_mem_flush;

  // A load targeting r0 never produces a usable value, so it never stalls.
  assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    if (state_q == MULTI) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
      if (rem_q == 8'd1) begin
        state_d = RELEASE;
        rem_d   = 8'd0;
      end else begin
        rem_d = rem_q - 8'd1;
      end
    end else begin
      state_d = RUN;
      if (hz.ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if ((state_q == RUN) && hz.ex_multicycle) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        rem_d        = REM_LOAD;
        state_d      = (REM_LOAD != 8'd0) ? MULTI : RELEASE;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (hz.id_jump) begin
        if_id_flush = 1'b1;
      end
    end

    // Reset forces the pipeline into a safe hold regardless of state.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else if (hz.perf_clear) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if ((if_id_flush || id_ex_flush) && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_write  = id_ex_write;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.state        = state_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table with a
// scoreboard queue, plus reset-mid-freeze and counter saturation sequences.
module tb_pipeline_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if hz_if ();

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz_if)
  );

  always #5 clock = ~clock;

  // ctrl packing: {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush}
  typedef struct {
    logic [4:0] rs, rt, ert;
    logic       ur, jmp, mr, mc, br, pc;
    logic [5:0] ctrl;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    int          idx;
    logic [5:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [15:0] m_stall = 16'd0;
  logic [15:0] m_flush = 16'd0;

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic ur, logic jmp,
                              logic mr, logic [4:0] ert, logic mc, logic br,
                              logic pc, logic [5:0] ctrl, logic [1:0] st);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ur = ur; v.jmp = jmp; v.mr = mr; v.ert = ert;
    v.mc = mc; v.br = br; v.pc = pc; v.ctrl = ctrl; v.st = st;
    return v;
  endfunction

  function automatic logic [5:0] ctrl_act();
    return {hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write,
            hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_mem_flush};
  endfunction

  task automatic chk(string nm, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    hz_if.id_rs           = v.rs;
    hz_if.id_rt           = v.rt;
    hz_if.id_uses_rt      = v.ur;
    hz_if.id_jump         = v.jmp;
    hz_if.ex_memread      = v.mr;
    hz_if.ex_rt           = v.ert;
    hz_if.ex_multicycle   = v.mc;
    hz_if.ex_branch_taken = v.br;
    hz_if.perf_clear      = v.pc;
  endtask

  task automatic apply(vec_t v, int idx);
    exp_t e;
    @(posedge clock);
    #1;
    drive(v);
    e.idx = idx; e.ctrl = v.ctrl; e.st = v.st; e.stall = m_stall; e.flush = m_flush;
    sb.push_back(e);
    // counters after the coming edge, from the expected outputs of this cycle
    if (v.pc) begin
      m_stall = 16'd0;
      m_flush = 16'd0;
    end else begin
      if (!v.ctrl[5] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if ((v.ctrl[2] || v.ctrl[1]) && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
    @(negedge clock);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("ctrl",  e.idx, 16'(ctrl_act()), 16'(e.ctrl));
      chk("state", e.idx, 16'(hz_if.state), 16'(e.st));
      chk("stall_cycles", e.idx, hz_if.stall_cycles, e.stall);
      chk("flush_count",  e.idx, hz_if.flush_count, e.flush);
    end
  endtask

  localparam logic [5:0] C_IDLE = 6'b111000;
  localparam logic [5:0] C_RST  = 6'b000111;
  localparam logic [5:0] C_LU   = 6'b001010;
  localparam logic [5:0] C_BR   = 6'b111110;
  localparam logic [5:0] C_JMP  = 6'b111100;
  localparam logic [5:0] C_FRZ  = 6'b000001;

  initial begin
    //             rs  rt  ur jmp mr ert mc br pc  ctrl    st
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, C_IDLE, 0)); // 0 idle
    vecs.push_back(mk(5,  0,  0, 0, 1, 5, 0, 0, 0, C_LU,   0)); // 1 load-use rs
    vecs.push_back(mk(5,  0,  0, 0, 0, 5, 0, 0, 0, C_IDLE, 0)); // 2 bubble cleared
    vecs.push_back(mk(0,  0,  1, 0, 1, 0, 0, 0, 0, C_IDLE, 0)); // 3 load to r0
    vecs.push_back(mk(3,  7,  1, 0, 1, 7, 0, 0, 0, C_LU,   0)); // 4 load-use rt
    vecs.push_back(mk(3,  7,  0, 0, 1, 7, 0, 0, 0, C_IDLE, 0)); // 5 rt not a source
    vecs.push_back(mk(5,  0,  0, 0, 1, 5, 0, 1, 0, C_BR,   0)); // 6 branch + load-use
    vecs.push_back(mk(1,  2,  0, 1, 0, 0, 0, 0, 0, C_JMP,  0)); // 7 jump
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 1, 0, 0, C_FRZ,  0)); // 8 freeze start
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 1, 1, 0, C_FRZ,  1)); // 9 branch ignored
    vecs.push_back(mk(0,  0,  0, 1, 0, 0, 1, 0, 0, C_FRZ,  1)); // 10 jump ignored
    vecs.push_back(mk(0,  0,  0, 1, 0, 0, 1, 0, 0, C_JMP,  2)); // 11 release, jump
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, C_IDLE, 0)); // 12
    vecs.push_back(mk(9,  0,  0, 0, 1, 9, 1, 0, 0, C_FRZ,  0)); // 13 mc beats load-use
    vecs.push_back(mk(9,  0,  0, 0, 1, 9, 1, 0, 0, C_FRZ,  1)); // 14
    vecs.push_back(mk(9,  0,  0, 0, 1, 9, 1, 0, 0, C_FRZ,  1)); // 15
    vecs.push_back(mk(9,  0,  0, 0, 1, 9, 1, 0, 0, C_LU,   2)); // 16 load-use in release
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 1, C_IDLE, 0)); // 17 perf_clear
    vecs.push_back(mk(4,  0,  0, 0, 1, 4, 0, 0, 1, C_LU,   0)); // 18 clear beats stall
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, C_IDLE, 0)); // 19
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 1, 1, 0, C_BR,   0)); // 20 branch beats mc
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, C_IDLE, 0)); // 21
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 1, 0, 0, C_FRZ,  0)); // 22 freeze start
    vecs.push_back(mk(0,  0,  0, 0, 0, 0, 1, 0, 0, C_FRZ,  1)); // 23 first MULTI

    // reset held low with random inputs
    hz_if.id_rs           = 5'($urandom);
    hz_if.id_rt           = 5'($urandom);
    hz_if.id_uses_rt      = 1'($urandom);
    hz_if.id_jump         = 1'($urandom);
    hz_if.ex_memread      = 1'($urandom);
    hz_if.ex_rt           = 5'($urandom);
    hz_if.ex_multicycle   = 1'($urandom);
    hz_if.ex_branch_taken = 1'($urandom);
    hz_if.perf_clear      = 1'($urandom);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_ctrl",  -1, 16'(ctrl_act()), 16'(C_RST));
    chk("reset_state", -1, 16'(hz_if.state), 16'd0);
    chk("reset_stall", -1, hz_if.stall_cycles, 16'd0);
    chk("reset_flush", -1, hz_if.flush_count, 16'd0);
    drive(vecs[0]);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // second MULTI cycle: assert reset mid-freeze
    @(posedge clock);
    #1;
    chk("pre_reset_state", 24, 16'(hz_if.state), 16'd1);
    reset = 1'b0;
    #1;
    chk("midfreeze_reset_ctrl",  24, 16'(ctrl_act()), 16'(C_RST));
    chk("midfreeze_reset_state", 24, 16'(hz_if.state), 16'd0);
    chk("midfreeze_reset_stall", 24, hz_if.stall_cycles, 16'd0);
    drive(vecs[0]);
    @(negedge clock);
    reset   = 1'b1;
    m_stall = 16'd0;
    m_flush = 16'd0;
    apply(vecs[0], 25);
    apply(vecs[0], 26);

    // saturation: hold a load-use match (no bubble feedback in the bench)
    @(posedge clock);
    #1;
    drive(vecs[1]);
    repeat (65536) @(posedge clock);
    @(negedge clock);
    chk("sat_pc_write", 27, 16'(hz_if.pc_write), 16'd0);
    chk("sat_stall",    27, hz_if.stall_cycles, 16'hFFFF);
    chk("sat_flush",    27, hz_if.flush_count, 16'hFFFF);
    hz_if.perf_clear = 1'b1;
    @(negedge clock);
    chk("clear_stall", 28, hz_if.stall_cycles, 16'd0);
    chk("clear_flush", 28, hz_if.flush_count, 16'd0);
    chk("clear_state", 28, 16'(hz_if.state), 16'd0);
    hz_if.perf_clear = 1'b0;
    @(negedge clock);
    chk("recount_stall", 29, hz_if.stall_cycles, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It watches the decode stage and the outputs of the ID/EX register, and drives the `write` and flush (`reset`) inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It handles four cases: load-use bubbles, taken-branch flushes, jump slot squash, and multi-cycle EX freezes. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MULDIV_CYCLES, 4, total EX-stage occupancy of a multi-cycle op in cycles; legal range 2..255
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  the ID instruction reads rt as a source
- id_jump  in  1  the ID instruction is J/JAL
- ex_memread  in  1  MemRead out of ID/EX
- ex_rt  in  5  RT out of ID/EX (load destination)
- ex_multicycle  in  1  the ID/EX instruction is a multi-cycle ALU op
- ex_branch_taken  in  1  the branch in EX resolved taken
- perf_clear  in  1  synchronous clear of both counters
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID clear
- id_ex_write  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX clear (bubble)
- ex_mem_flush  out  1  EX/MEM clear (bubble)
- state  out  2  RUN=0, MULTI=1, RELEASE=2
- stall_cycles  out  16  saturating count of cycles with pc_write=0
- flush_count  out  16  saturating count of flush events

## Operation
- **Reset asserted:**
  - state=RUN, remaining counter=0, both perf counters=0.
  - Outputs forced: all write enables=0, all flushes=1.
- **RUN:** priority order, highest first.
  1. ex_branch_taken → pc_write=1, if_id_flush=1, id_ex_flush=1; all other writes 1.
  2. ex_multicycle → freeze.
     - Freeze means pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1, other flushes 0.
     - Load remaining=MULDIV_CYCLES-2.
     - Next state is MULTI if remaining≠0, else RELEASE.
  3. Load-use, detected when ex_memread and ex_rt≠0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)):
     - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1.
     - Purely combinational. The bubble clears ex_memread, so the stall self-terminates after one cycle.
  4. id_jump → if_id_flush=1, all writes 1.
  5. Otherwise all writes=1 and all flushes=0.
- **MULTI:**
  - Freeze outputs.
  - All hazard inputs are ignored.
  - If remaining==1, go to RELEASE; else remaining−1.
- **RELEASE:**
  - One cycle. ex_multicycle is ignored (ID/EX still holds the op).
  - Rules 1, 3, 4 and 5 apply.
  - Next state is RUN.
- **Freeze length:** exactly MULDIV_CYCLES−1 consecutive cycles. The op advances at the edge ending its MULDIV_CYCLES-th EX cycle.
- **stall_cycles:**
  - +1 on each edge where pc_write=0.
  - Holds at 16'hFFFF.
- **flush_count:**
  - +1 on each edge where if_id_flush or id_ex_flush is asserted (a branch counts once).
  - Holds at 16'hFFFF.
- **perf_clear:**
  - Zeroes both counters.
  - Takes priority over increment in the same cycle.
  - Has no effect on state.
- **Counter width:** the remaining counter is 8 bits.

## Timing
- All hazard outputs are combinational from the current state and inputs.
  - state, remaining and the perf counters are registered.
  - Target settle time is before the pipeline-register capture edge in the same cycle.
- Reset assertion takes effect immediately, mid-freeze included.
  - Deassertion is asynchronous; the first edge after deassertion evaluates RUN.
- **Simultaneous events:**
  - Branch+load-use: the flush wins, no stall.
  - Multicycle+jump: freeze wins; the jump is handled in RELEASE.
- **Register 0:** a load with ex_rt=0 never stalls.
- **MULDIV_CYCLES=2:** single freeze cycle, then RELEASE; MULTI is skipped.

## Test plan
- Reset low with random inputs → writes all 0, flushes all 1. Release, idle inputs → pc_write=if_id_write=id_ex_write=1, flushes 0, state=0.
- ex_memread=1, ex_rt=5, id_rs=5 → one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles=1. Repeat with ex_rt=0 → no stall.
- MULDIV_CYCLES=4, ex_multicycle held 1 → freeze for exactly 3 cycles (state 0,1,1), then state=2 with writes 1, then state=0; stall_cycles=3, no retrigger.
- ex_branch_taken=1 together with a load-use match → if_id_flush=id_ex_flush=1, pc_write=1, flush_count+1, stall_cycles unchanged.
- Reset asserted in the second MULTI cycle → outputs forced immediately; after release state=0, counters=0.
- Force 65,536 stall cycles → stall_cycles holds 16'hFFFF. perf_clear with a concurrent stall → 0.
